// File: rtl/smart_toilet_dose_ctrl_pkg.sv
// Shared types and constants for the smart_toilet inlet dosing controller.
package smart_toilet_pkg;

    localparam int N_INLETS = 3;
    localparam int SOLN1    = 0;
    localparam int SOLN2    = 1;
    localparam int SOLN3    = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DOSE     = 3'd1,
        SETTLE   = 3'd2,
        WAIT_OUT = 3'd3,
        DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/smart_toilet_dose_ctrl_dose_channel.sv
// One inlet: loadable saturating down-counter of remaining pump steps.
module dose_channel
    import smart_toilet_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             step_en,
    input  logic             clear,
    output logic [CNT_W-1:0] remaining,
    output logic             valve,
    output logic             step
);

    logic [CNT_W-1:0] rem_q, rem_d;
    logic             nonzero;

    assign nonzero = (rem_q != '0);

    always_comb begin
        rem_d = rem_q;
        if (clear) begin
            rem_d = '0;
        end else if (load) begin
            rem_d = load_val;
        end else if (step_en && nonzero) begin
            rem_d = rem_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign remaining = rem_q;
    assign valve     = nonzero;
    assign step      = step_en && nonzero;

endmodule

// File: rtl/smart_toilet_dose_ctrl.sv
// Inlet-side dose sequencer: dose three inlets, settle, then wait for the outlet sensor.
module smart_toilet_dose_ctrl
    import smart_toilet_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int STEP_DIV = 100,
    parameter int TIMEOUT  = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] vol1,
    input  logic [CNT_W-1:0] vol2,
    input  logic [CNT_W-1:0] vol3,
    input  logic [CNT_W-1:0] settle,
    input  logic             outlet_detect,
    output logic [2:0]       valve_open,
    output logic [2:0]       pump_step,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             timeout_err
);

    localparam int PW = $clog2(STEP_DIV);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == CNT_MAX) ? x : x + CNT_W'(1);
    endfunction

    state_e           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tc_q, tc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic             terr_q, terr_d;
    logic             aborted_q, aborted_d;
    logic             det_q1, det_q2;

    logic [CNT_W-1:0] vol_arr [N_INLETS];
    logic [CNT_W-1:0] rem     [N_INLETS];
    logic [N_INLETS-1:0] valve_w, step_w;
    logic             load, abort_take, step_en, any_rem;

    assign load       = (state_q == IDLE) && start;
    assign abort_take = (state_q != IDLE) && abort;
    // A step due in the same cycle as an abort is dropped.
    assign step_en    = tc_q && (state_q == DOSE) && !abort;

    always_comb begin
        vol_arr[SOLN1] = vol1;
        vol_arr[SOLN2] = vol2;
        vol_arr[SOLN3] = vol3;
    end

    for (genvar i = 0; i < N_INLETS; i++) begin : g_ch
        dose_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load),
            .load_val  (vol_arr[i]),
            .step_en   (step_en),
            .clear     (abort_take),
            .remaining (rem[i]),
            .valve     (valve_w[i]),
            .step      (step_w[i])
        );
    end

    always_comb begin
        any_rem = 1'b0;
        for (int i = 0; i < N_INLETS; i++) begin
            any_rem = any_rem | (rem[i] != '0);
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = '0;
        tc_d      = 1'b0;
        cnt_d     = cnt_q;
        settle_d  = settle_q;
        terr_d    = terr_q;
        aborted_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d  = DOSE;
                    settle_d = settle;
                    terr_d   = 1'b0;
                end
            end
            DOSE: begin
                if (!any_rem) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else begin
                    // tc_q lags the terminal count by one cycle, so the first
                    // step lands STEP_DIV cycles after DOSE entry.
                    tc_d    = (presc_q == PRESC_LAST);
                    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
                end
            end
            SETTLE: begin
                if ((settle_q == '0) || (cnt_q >= settle_q - CNT_W'(1))) begin
                    state_d = WAIT_OUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            WAIT_OUT: begin
                if (det_q2) begin
                    state_d = DONE;
                end else if (cnt_q >= TO_LAST) begin
                    state_d = IDLE;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort_take) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
            tc_d      = 1'b0;
            presc_d   = '0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            tc_q      <= 1'b0;
            cnt_q     <= '0;
            settle_q  <= '0;
            terr_q    <= 1'b0;
            aborted_q <= 1'b0;
            det_q1    <= 1'b0;
            det_q2    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tc_q      <= tc_d;
            cnt_q     <= cnt_d;
            settle_q  <= settle_d;
            terr_q    <= terr_d;
            aborted_q <= aborted_d;
            det_q1    <= outlet_detect;
            det_q2    <= det_q1;
        end
    end

    assign valve_open  = valve_w;
    assign pump_step   = step_w;
    assign busy        = (state_q == DOSE) || (state_q == SETTLE) || (state_q == WAIT_OUT);
    assign done        = (state_q == DONE);
    assign aborted     = aborted_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_smart_toilet_dose_ctrl.sv
// Randomized scoreboard bench for smart_toilet_dose_ctrl against a cycle-timeline model.
module tb_smart_toilet_dose_ctrl;

    localparam int CNT_W = 16;
    localparam int SD    = 4;
    localparam int TO    = 20;
    localparam int K_VALVE = 0, K_STEP = 1, K_BUSY = 2, K_DONE = 3, K_ABORT = 4, K_TERR = 5;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, outlet_detect = 1'b0;
    logic [CNT_W-1:0] vol1 = '0, vol2 = '0, vol3 = '0, settle = '0;
    logic [2:0] valve_open, pump_step;
    logic busy, done, aborted, timeout_err;

    smart_toilet_dose_ctrl #(.CNT_W(CNT_W), .STEP_DIV(SD), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .vol1(vol1), .vol2(vol2), .vol3(vol3), .settle(settle),
        .outlet_detect(outlet_detect), .valve_open(valve_open), .pump_step(pump_step),
        .busy(busy), .done(done), .aborted(aborted), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    typedef struct {int cyc; int kind; logic [2:0] val;} ev_t;
    ev_t expq[$];
    ev_t tmp[$];
    ev_t mon_e;
    bit  m_terr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        int n = 0;
        while (cyc < t && n < 5000) begin
            tick();
            n++;
        end
    endtask

    // ---------------- monitor: one event per observed output change/pulse
    logic [2:0] pv_valve = '0;
    logic pv_busy = 1'b0, pv_terr = 1'b0;

    task automatic see(input int kind, input logic [2:0] v);
        checks++;
        if (expq.size() == 0 || expq[0].cyc != cyc) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d kind=%0d got=%0h", cyc, kind, v);
        end else begin
            mon_e = expq.pop_front();
            if (mon_e.kind != kind || mon_e.val != v) begin
                errors++;
                $display("FAIL event cyc=%0d got kind=%0d val=%0h expected kind=%0d val=%0h",
                         cyc, kind, v, mon_e.kind, mon_e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            pv_valve = valve_open;
            pv_busy  = busy;
            pv_terr  = timeout_err;
        end else begin
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                mon_e = expq.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event cyc=%0d kind=%0d got=none expected=%0h",
                         mon_e.cyc, mon_e.kind, mon_e.val);
            end
            if (valve_open != pv_valve) see(K_VALVE, valve_open);
            if (pump_step != 3'b000)    see(K_STEP, pump_step);
            if (busy != pv_busy)        see(K_BUSY, {2'b00, busy});
            if (done)                   see(K_DONE, 3'b001);
            if (aborted)                see(K_ABORT, 3'b001);
            if (timeout_err != pv_terr) see(K_TERR, {2'b00, timeout_err});
            pv_valve = valve_open;
            pv_busy  = busy;
            pv_terr  = timeout_err;
        end
    end

    // ---------------- reference model: expected event timeline of one sequence
    function automatic int max3(input int a, input int b, input int c);
        int m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // First WAIT_OUT cycle for a sequence whose DOSE begins at cycle d.
    function automatic int calc_w(input int d, input int v0, input int v1, input int v2, input int s);
        int mx = max3(v0, v1, v2);
        int dose_last = (mx == 0) ? d : d + SD * mx + 1;
        return dose_last + 1 + ((s == 0) ? 1 : s);
    endfunction

    task automatic add_ev(input int c, input int k, input logic [2:0] v);
        ev_t e;
        e.cyc = c; e.kind = k; e.val = v;
        tmp.push_back(e);
    endtask

    task automatic build(input int d, input int v0, input int v1, input int v2,
                         input int s, input int a, input int t_on);
        int vv[3];
        int mx, w, tdet;
        logic [2:0] pv, cv;
        ev_t sw;
        tmp.delete();
        vv[0] = v0; vv[1] = v1; vv[2] = v2;
        mx = max3(v0, v1, v2);
        w  = calc_w(d, v0, v1, v2, s);
        if (m_terr) begin
            add_ev(d, K_TERR, 3'b000);
            m_terr = 1'b0;
        end
        add_ev(d, K_BUSY, 3'b001);
        pv = '0;
        for (int t = d; t <= d + SD * mx + 2; t++) begin
            cv = '0;
            for (int i = 0; i < 3; i++)
                if (vv[i] > 0 && t <= d + SD * vv[i] && (a < 0 || t <= a)) cv[i] = 1'b1;
            if (cv != pv) add_ev(t, K_VALVE, cv);
            pv = cv;
        end
        for (int j = 1; j <= mx; j++) begin
            if (a < 0 || d + SD * j < a) begin
                cv = '0;
                for (int i = 0; i < 3; i++) if (vv[i] >= j) cv[i] = 1'b1;
                add_ev(d + SD * j, K_STEP, cv);
            end
        end
        if (a >= 0) begin
            add_ev(a + 1, K_BUSY, 3'b000);
            add_ev(a + 1, K_ABORT, 3'b001);
        end else begin
            tdet = (t_on + 2 > w) ? t_on + 2 : w;
            if (tdet <= w + TO - 1) begin
                add_ev(tdet + 1, K_BUSY, 3'b000);
                add_ev(tdet + 1, K_DONE, 3'b001);
            end else begin
                add_ev(w + TO, K_BUSY, 3'b000);
                add_ev(w + TO, K_TERR, 3'b001);
                m_terr = 1'b1;
            end
        end
        for (int i = 1; i < tmp.size(); i++)
            for (int j = i; j > 0 && (tmp[j-1].cyc * 8 + tmp[j-1].kind) > (tmp[j].cyc * 8 + tmp[j].kind); j--) begin
                sw = tmp[j-1]; tmp[j-1] = tmp[j]; tmp[j] = sw;
            end
        foreach (tmp[i]) expq.push_back(tmp[i]);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (expq.size() > 0 && n < 400) begin
            tick();
            n++;
        end
        check(name, expq.size(), 0);
        expq.delete();
    endtask

    // mode 0: detect already high, 1: detect raised off cycles after WAIT_OUT entry, 2: never.
    // aoff: -1 no abort, -2 random abort cycle, >=0 abort at DOSE entry + aoff.
    task automatic run_txn(input string name, input int v0, input int v1, input int v2, input int s,
                           input int mode, input int off, input int aoff, input bit spam);
        int k, d, w, a, t_on;
        if (mode == 0) begin
            outlet_detect = 1'b1;
            repeat (3) tick();
        end
        vol1 = CNT_W'(v0); vol2 = CNT_W'(v1); vol3 = CNT_W'(v2); settle = CNT_W'(s);
        start = 1'b1;
        k = cyc;
        d = k + 1;
        w = calc_w(d, v0, v1, v2, s);
        if (aoff == -2) a = d + $urandom_range(0, w - d - 1);
        else if (aoff >= 0) a = d + aoff;
        else a = -1;
        t_on = (mode == 0) ? k - 3 : (mode == 1) ? w + off : (1 << 28);
        build(d, v0, v1, v2, s, a, t_on);
        tick();
        start = 1'b0;
        vol1 = CNT_W'($urandom); vol2 = CNT_W'($urandom); vol3 = CNT_W'($urandom);
        settle = CNT_W'($urandom);
        if (spam && a < 0) begin
            repeat (2) begin
                tick(); start = 1'b1;
                tick(); start = 1'b0;
                vol1 = CNT_W'($urandom); settle = CNT_W'($urandom);
            end
        end
        if (a >= 0) begin
            wait_cyc(a);
            abort = 1'b1;
            tick();
            abort = 1'b0;
        end else if (mode == 1) begin
            wait_cyc(t_on);
            outlet_detect = 1'b1;
        end
        drain(name);
        outlet_detect = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        int v0, v1, v2, s, r, mode, off, aoff;
        int d;
        repeat (3) tick();
        check("reset_valve", valve_open, 0);
        check("reset_pump", pump_step, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_aborted", aborted, 0);
        check("reset_terr", timeout_err, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        run_txn("basic_123", 1, 2, 3, 5, 1, 10, -1, 1'b0);
        run_txn("all_zero", 0, 0, 0, 0, 0, 0, -1, 1'b0);
        run_txn("timeout", 1, 0, 0, 2, 2, 0, -1, 1'b0);
        check("terr_sticky", timeout_err, 1);
        run_txn("terr_clear", 0, 2, 0, 1, 1, 3, -1, 1'b0);
        run_txn("abort_step2", 5, 5, 5, 3, 2, 0, 2 * SD, 1'b0);
        run_txn("after_abort", 2, 1, 3, 2, 1, 0, -1, 1'b0);
        run_txn("start_spam", 3, 0, 2, 4, 1, 5, -1, 1'b1);
        run_txn("detect_edge", 1, 1, 1, 1, 1, TO - 3, -1, 1'b0);

        // asynchronous reset while in SETTLE
        vol1 = 16'd1; vol2 = '0; vol3 = '0; settle = 16'd6;
        start = 1'b1;
        d = cyc + 1;
        build(d, 1, 0, 0, 6, -1, (1 << 28));
        tick();
        start = 1'b0;
        wait_cyc(d + SD + 4);
        check("pre_reset_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("areset_busy", busy, 0);
        check("areset_valve", valve_open, 0);
        check("areset_pump", pump_step, 0);
        check("areset_done", done, 0);
        check("areset_aborted", aborted, 0);
        check("areset_terr", timeout_err, 0);
        expq.delete();
        m_terr = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) tick();
        check("post_reset_idle", busy, 0);
        run_txn("post_reset", 2, 2, 0, 0, 1, 1, -1, 1'b0);

        for (int t = 0; t < 25; t++) begin
            v0 = $urandom_range(0, 4); v1 = $urandom_range(0, 4); v2 = $urandom_range(0, 4);
            s = $urandom_range(0, 6);
            r = $urandom_range(0, 9);
            mode = (r < 2) ? 0 : (r < 8) ? 1 : 2;
            off = $urandom_range(0, 22);
            aoff = ($urandom_range(0, 4) == 0) ? -2 : -1;
            run_txn("random", v0, v1, v2, s, mode, off, aoff, (max3(v0, v1, v2) > 0) && ($urandom_range(0, 1) == 1));
        end

        check("queue_empty", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
